// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble) feeding the
// FND digit-mux/decoder. One conversion takes BIN_W shift cycles plus one
// result cycle, with results visible BIN_W+1 cycles after the accept edge.
// Out-of-range inputs saturate to all nines. Leading zeros can optionally be
// blanked.
//
// Ports
//   i_clk       system clock, rising edge
//   i_reset     asynchronous reset, active-high
//   i_start     conversion request, accepted only when idle
//   i_bin       unsigned binary value, sampled on the accept edge
//   i_blank_en  leading-zero blanking enable, sampled on the accept edge
//   o_busy      high from the accept edge until o_done falls
//   o_done      one-cycle pulse, result outputs just updated
//   o_bcd       packed BCD result, units digit in [3:0]
//   o_digit_en  per-digit display enable, bit 0 = units
//   o_overflow  last result saturated (i_bin > 10^DIGITS-1)
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  input  logic                  i_blank_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_digit_en,
  output logic                  o_overflow
);

  localparam int unsigned BW    = 4 * DIGITS;
  localparam int unsigned SW    = BW + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_bcd_value();
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  // Largest value representable in DIGITS decimal digits. When 2^BIN_W-1
  // never exceeds it, the overflow compare reduces to a constant 0.
  localparam logic [63:0] MAX_VAL = max_bcd_value();

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     scratch, scratch_n, adj;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              blank_q, blank_n;
  logic              ovf_q, ovf_n;
  logic              busy_n, done_n, overflow_n;
  logic [BW-1:0]     bcd_n;
  logic [DIGITS-1:0] en_n, en_calc;
  logic              seen;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      scratch    <= '0;
      cnt        <= '0;
      blank_q    <= 1'b0;
      ovf_q      <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_bcd      <= '0;
      o_digit_en <= DIGITS'(1);
      o_overflow <= 1'b0;
    end else begin
      state      <= state_n;
      scratch    <= scratch_n;
      cnt        <= cnt_n;
      blank_q    <= blank_n;
      ovf_q      <= ovf_n;
      o_busy     <= busy_n;
      o_done     <= done_n;
      o_bcd      <= bcd_n;
      o_digit_en <= en_n;
      o_overflow <= overflow_n;
    end
  end

  always_comb begin
    state_n    = state;
    scratch_n  = scratch;
    cnt_n      = cnt;
    blank_n    = blank_q;
    ovf_n      = ovf_q;
    busy_n     = o_busy;
    done_n     = 1'b0;
    bcd_n      = o_bcd;
    en_n       = o_digit_en;
    overflow_n = o_overflow;
    adj        = scratch;
    en_calc    = DIGITS'(1);
    seen       = 1'b0;

    case (state)
      ST_IDLE: begin
        // o_busy drops here, in step with the o_done pulse, unless a new
        // request is accepted on the same edge.
        busy_n = 1'b0;
        if (i_start) begin
          scratch_n = SW'(i_bin);
          blank_n   = i_blank_en;
          ovf_n     = 64'(i_bin) > MAX_VAL;
          cnt_n     = '0;
          busy_n    = 1'b1;
          state_n   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        for (int unsigned j = 0; j < DIGITS; j++) begin
          if (adj[BIN_W + 4*j +: 4] >= 4'd5)
            adj[BIN_W + 4*j +: 4] = adj[BIN_W + 4*j +: 4] + 4'd3;
        end
        scratch_n = {adj[SW-2:0], 1'b0};
        cnt_n     = cnt + 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) state_n = ST_DONE;
      end

      ST_DONE: begin
        // Scan from the top digit down: a digit stays lit once any digit at
        // or above it is non-zero. The units digit is always lit.
        for (int unsigned j = 1; j < DIGITS; j++) begin
          seen = seen | (scratch[BIN_W + 4*(DIGITS-j) +: 4] != 4'd0);
          en_calc[DIGITS-j] = seen;
        end
        bcd_n      = ovf_q ? {DIGITS{4'h9}} : scratch[SW-1 -: BW];
        en_n       = (!blank_q || ovf_q) ? '1 : en_calc;
        overflow_n = ovf_q;
        done_n     = 1'b1;
        state_n    = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule
